// File: rtl/pipeline_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipeline_pkg
// Brief    : Shared types for the rv64i stage registers (skid FSM + stage payloads)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

    // Encoding equals occupancy so the state register doubles as the count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } IFID_Pipe_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
    } IDEX_Pipe_t;

    typedef struct packed {
        logic [63:0] alu_res;
        logic [63:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
    } EXMEM_Pipe_t;

    typedef struct packed {
        logic [63:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } MEMWB_Pipe_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
//------------------------------------------------------------------------------
// Module   : pipe_skid_reg
// Brief    : Elastic valid/ready stage register with a 2-entry skid buffer
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_skid_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned WIDTH         = 64,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       occupancy_o
);

    localparam logic [WIDTH-1:0] c_ZERO = '0;

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Ready depends only on the state register, never on out_ready_i.
    assign in_ready_o  = (r_state != FULL);
    assign out_valid_o = (r_state != EMPTY);
    assign occupancy_o = r_state;
    assign data_o      = r_main;

    assign w_in_xfer  = in_valid_i && in_ready_o;
    assign w_out_xfer = out_valid_o && out_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = BUSY;
                    w_main_nxt  = data_i;
                end
            end
            BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_nxt = data_i;
                end else if (w_in_xfer) begin
                    w_state_nxt = FULL;
                    w_skid_nxt  = data_i;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt = BUSY;
                    w_main_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase

        // A concurrent output transfer has already been consumed downstream.
        if (flush_i) begin
            w_state_nxt = EMPTY;
            if (ZERO_ON_FLUSH) begin
                w_main_nxt = c_ZERO;
                w_skid_nxt = c_ZERO;
            end else begin
                w_main_nxt = r_main;
                w_skid_nxt = r_skid;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
            r_main  <= c_ZERO;
            r_skid  <= c_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_skid_reg
// Brief    : Directed and randomised checks of pipe_skid_reg for both flush modes
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_skid_reg;

    localparam int unsigned c_W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           out_ready;
    logic [c_W-1:0] din;

    logic           z_in_ready, z_out_valid;
    logic [c_W-1:0] z_data;
    logic [1:0]     z_occ;
    logic           s_in_ready, s_out_valid;
    logic [c_W-1:0] s_data;
    logic [1:0]     s_occ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(c_W), .ZERO_ON_FLUSH(1'b1)) u_dut_zero (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(z_in_ready), .data_i(din),
        .out_valid_o(z_out_valid), .out_ready_i(out_ready),
        .data_o(z_data), .occupancy_o(z_occ)
    );

    pipe_skid_reg #(.WIDTH(c_W), .ZERO_ON_FLUSH(1'b0)) u_dut_stale (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(s_in_ready), .data_i(din),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .data_o(s_data), .occupancy_o(s_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [c_W-1:0] d, input logic r);
        in_valid  = v;
        din       = d;
        out_ready = r;
    endtask

    logic [c_W-1:0] q[$];
    logic           m_in, m_out;

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b1, 16'hDEAD, 1'b0);
        tick(); tick();
        chk("rst_out_valid", 32'(z_out_valid), 32'd0);
        chk("rst_in_ready",  32'(z_in_ready),  32'd1);
        chk("rst_occ",       32'(z_occ),       32'd0);
        chk("rst_data_z",    32'(z_data),      32'd0);
        chk("rst_data_s",    32'(s_data),      32'd0);

        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        tick();

        // streaming at one transfer per cycle
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, c_W'(i), 1'b1);
            tick();
            chk("stream_data",     32'(z_data),      32'(i));
            chk("stream_occ",      32'(z_occ),       32'd1);
            chk("stream_in_ready", 32'(z_in_ready),  32'd1);
            chk("stream_valid",    32'(z_out_valid), 32'd1);
        end
        drive(1'b0, '0, 1'b1);
        tick();
        chk("stream_drain_occ", 32'(z_occ), 32'd0);

        // backpressure fills the skid
        drive(1'b1, 16'h000A, 1'b0);
        tick();
        chk("bp_occ1", 32'(z_occ), 32'd1);
        drive(1'b1, 16'h000B, 1'b0);
        tick();
        chk("bp_full_occ",      32'(z_occ),      32'd2);
        chk("bp_full_in_ready", 32'(z_in_ready), 32'd0);
        chk("bp_full_data",     32'(z_data),     32'h000A);
        drive(1'b1, 16'h000C, 1'b0);
        tick();
        chk("bp_reject_occ",  32'(z_occ),  32'd2);
        chk("bp_reject_data", 32'(z_data), 32'h000A);
        drive(1'b1, 16'h000C, 1'b1);
        tick();
        chk("bp_pop_a_data",     32'(z_data),     32'h000B);
        chk("bp_pop_a_occ",      32'(z_occ),      32'd1);
        chk("bp_pop_a_in_ready", 32'(z_in_ready), 32'd1);
        tick();
        chk("bp_accept_c_data", 32'(z_data), 32'h000C);
        chk("bp_accept_c_occ",  32'(z_occ),  32'd1);
        drive(1'b0, '0, 1'b1);
        tick();
        chk("bp_drain_occ", 32'(z_occ), 32'd0);

        // flush while full drops skid and the offered input
        drive(1'b1, 16'h0011, 1'b0); tick();
        drive(1'b1, 16'h0022, 1'b0); tick();
        chk("fl_pre_occ",  32'(z_occ),  32'd2);
        chk("fl_pre_data", 32'(z_data), 32'h0011);
        flush = 1'b1;
        drive(1'b1, 16'h0033, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        chk("fl_occ",       32'(z_occ),       32'd0);
        chk("fl_out_valid", 32'(z_out_valid), 32'd0);
        chk("fl_data_zero", 32'(z_data),      32'd0);
        chk("fl_in_ready",  32'(z_in_ready),  32'd1);
        chk("fl_data_stale",32'(s_data),      32'h0011);
        tick();
        chk("fl_post_valid", 32'(z_out_valid), 32'd0);
        chk("fl_post_occ",   32'(s_occ),       32'd0);

        // stale payload kept when zeroing is disabled
        drive(1'b1, 16'h0055, 1'b0); tick();
        flush = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        flush = 1'b0;
        chk("zof0_valid", 32'(s_out_valid), 32'd0);
        chk("zof0_data",  32'(s_data),      32'h0055);
        chk("zof1_data",  32'(z_data),      32'd0);

        // reset beats flush, both zero regardless of mode
        drive(1'b1, 16'h0066, 1'b0); tick();
        drive(1'b1, 16'h0077, 1'b0); tick();
        chk("prio_pre_occ", 32'(s_occ), 32'd2);
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        chk("prio_occ_z",  32'(z_occ),  32'd0);
        chk("prio_occ_s",  32'(s_occ),  32'd0);
        chk("prio_data_z", 32'(z_data), 32'd0);
        chk("prio_data_s", 32'(s_data), 32'd0);

        // randomised traffic against a queue model
        q.delete();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), c_W'($urandom), 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 99) < 20);
            m_out = (q.size() > 0) && out_ready;
            m_in  = in_valid && (q.size() < 2);
            tick();
            if (m_out) void'(q.pop_front());
            if (flush) q.delete();
            else if (m_in) q.push_back(din);
            chk("rnd_occ_z",      32'(z_occ),      32'(q.size()));
            chk("rnd_occ_s",      32'(s_occ),      32'(q.size()));
            chk("rnd_in_ready",   32'(z_in_ready), 32'(q.size() < 2));
            chk("rnd_out_valid",  32'(z_out_valid),32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_data_z", 32'(z_data), 32'(q[0]));
                chk("rnd_data_s", 32'(s_data), 32'(q[0]));
            end else if (flush) begin
                chk("rnd_flush_zero", 32'(z_data), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
